// File: rtl/interrupt_conditioner_pkg.sv
// Shared types and constants for the interrupt conditioner.
// Holds the request FSM state encoding, the holdoff counter width, the
// request-id width and the lowest-set-index helper used for arbitration.
package interrupt_conditioner_pkg;

  localparam int CNT_W      = 4;
  localparam int ID_W       = 3;
  localparam int MAX_INPUTS = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  // Index of the lowest set bit; 0 when the vector is empty. Scanning from
  // the top means the last hit written is the lowest index.
  function automatic logic [ID_W-1:0] lowest_index(input logic [MAX_INPUTS-1:0] vec);
    logic [ID_W-1:0] idx;
    idx = {ID_W{1'b0}};
    for (int i = MAX_INPUTS - 1; i >= 0; i--) begin
      idx = vec[i] ? ID_W'(i) : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/interrupt_conditioner_sync.sv
// One interrupt line: SYNC_STAGES-deep synchronizer, optional two-sample
// glitch filter, and a registered rising-edge detector.
// Optional feature macro: INTERRUPT_CONDITIONER_GLITCH_FILTER_EN
//   defined -> the synchronized level must be high two cycles in a row.
// Ports:
//   i_clk   clock
//   i_rst   asynchronous active-high reset
//   i_line  raw asynchronous interrupt line
//   o_edge  one-cycle pulse per recognized 0->1 transition
module interrupt_conditioner_sync
  import interrupt_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_line,
  output logic o_edge
);

`ifdef INTERRUPT_CONDITIONER_GLITCH_FILTER_EN
  localparam int VLEN = SYNC_STAGES + 2;
  logic filt_q;
  logic filt_d;
`else
  localparam int VLEN = SYNC_STAGES + 1;
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  // vld tracks which pipeline stages hold real post-reset samples, so a
  // line already high at reset release never looks like a fresh edge.
  logic [VLEN-1:0]        vld_q;
  logic [VLEN-1:0]        vld_d;
  logic                   prev_q;
  logic                   prev_d;
  logic                   edge_q;
  logic                   edge_d;
  logic                   level_s;

  // Next-state for synchronizer, filter and edge detector.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_line};
    vld_d  = {vld_q[VLEN-2:0], 1'b1};
`ifdef INTERRUPT_CONDITIONER_GLITCH_FILTER_EN
    filt_d  = sync_q[SYNC_STAGES-1];
    level_s = sync_q[SYNC_STAGES-1] & filt_q;
`else
    level_s = sync_q[SYNC_STAGES-1];
`endif
    prev_d = level_s;
    edge_d = level_s & ~prev_q & vld_q[VLEN-1];
  end

  // Pipeline registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= '0;
      vld_q  <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
`ifdef INTERRUPT_CONDITIONER_GLITCH_FILTER_EN
      filt_q <= 1'b0;
`endif
    end else begin
      sync_q <= sync_d;
      vld_q  <= vld_d;
      prev_q <= prev_d;
      edge_q <= edge_d;
`ifdef INTERRUPT_CONDITIONER_GLITCH_FILTER_EN
      filt_q <= filt_d;
`endif
    end
  end

  assign o_edge = edge_q;

endmodule

// File: rtl/interrupt_conditioner.sv
// Interrupt conditioner: synchronizes N_INPUTS asynchronous lines, latches
// rising edges into a pending vector, and presents one masked request at a
// time (lowest index first) to a downstream interrupt peripheral, with a
// programmable holdoff after every acknowledge.
// Optional feature macro: INTERRUPT_CONDITIONER_GLITCH_FILTER_EN (per-line
// glitch filter inside interrupt_conditioner_sync).
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_interrupt[N]      raw interrupt lines, rising edge significant
//   i_mask_wr, i_mask   mask load strobe and value (1 = source disabled)
//   i_int_ack           acknowledge of the current request
//   o_int_req, o_int_id registered request and its source index
//   o_pending[N]        pending latches, unmasked view
module interrupt_conditioner
  import interrupt_conditioner_pkg::*;
#(
  parameter int N_INPUTS       = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLDOFF_CYCLES = 3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [N_INPUTS-1:0] i_interrupt,
  input  logic                i_mask_wr,
  input  logic [N_INPUTS-1:0] i_mask,
  input  logic                i_int_ack,
  output logic                o_int_req,
  output logic [ID_W-1:0]     o_int_id,
  output logic [N_INPUTS-1:0] o_pending
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [N_INPUTS-1:0]   edge_s;
  logic [N_INPUTS-1:0]   avail_s;
  logic [N_INPUTS-1:0]   clr_s;
  logic [MAX_INPUTS-1:0] avail_ext_s;
  logic [N_INPUTS-1:0]   pending_q, pending_d;
  logic [N_INPUTS-1:0]   mask_q, mask_d;
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  req_q, req_d;
  logic [ID_W-1:0]       id_q, id_d;

  for (genvar g = 0; g < N_INPUTS; g++) begin : g_line
    interrupt_conditioner_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_line(i_interrupt[g]),
      .o_edge(edge_s[g])
    );
  end

  assign avail_s = pending_q & ~mask_q;

  // Zero-extend the arbitration vector to the helper's fixed width.
  always_comb begin
    avail_ext_s                 = '0;
    avail_ext_s[N_INPUTS-1:0]   = avail_s;
  end

  // Request FSM: arbitration, ack handling and holdoff countdown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    req_d   = req_q;
    clr_s   = '0;
    case (state_q)
      ST_IDLE: begin
        if (avail_s != '0) begin
          state_d = ST_REQ;
          id_d    = lowest_index(avail_ext_s);
          req_d   = 1'b1;
        end else begin
          req_d   = 1'b0;
        end
      end
      ST_REQ: begin
        // id and req are frozen here; mask writes and new edges only
        // affect the next arbitration.
        if (i_int_ack) begin
          for (int i = 0; i < N_INPUTS; i++) begin
            clr_s[i] = (id_q == ID_W'(i));
          end
          req_d = 1'b0;
          if (HOLD_LOAD == '0) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = ST_HOLDOFF;
            cnt_d   = HOLD_LOAD;
          end
        end else begin
          req_d = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        // Leaving on the 1->0 step makes the next request appear exactly
        // HOLDOFF_CYCLES+1 cycles after the ack.
        req_d = 1'b0;
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        req_d   = 1'b0;
      end
    endcase
  end

  // Pending latches (a new edge beats a same-cycle ack clear) and mask.
  always_comb begin
    pending_d = (pending_q & ~clr_s) | edge_s;
    if (i_mask_wr) begin
      mask_d = i_mask;
    end else begin
      mask_d = mask_q;
    end
  end

  // State registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pending_q <= '0;
      mask_q    <= '1;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      id_q      <= '0;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      id_q      <= id_d;
    end
  end

  assign o_int_req = req_q;
  assign o_int_id  = id_q;
  assign o_pending = pending_q;

endmodule

// File: doc/interrupt_conditioner.md
INTERRUPT_CONDITIONER -- requirements
Module: interrupt_conditioner

Interface
REQ-001 Parameter N_INPUTS, default 4, number of external interrupt sources (1..8).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flop depth per input (2..3).
REQ-003 Parameter HOLDOFF_CYCLES, default 3, dead cycles after ack before the next request (0..15).
REQ-004 i_clk  input  1  processor clock; all state on rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_interrupt  input  N_INPUTS  asynchronous external interrupt lines, rising-edge significant.
REQ-007 i_mask_wr  input  1  one-cycle strobe loading i_mask.
REQ-008 i_mask  input  N_INPUTS  mask value; bit=1 disables that source.
REQ-009 i_int_ack  input  1  one-cycle acknowledge from the processor interrupt peripheral.
REQ-010 o_int_req  output  1  registered request to the downstream interrupt peripheral.
REQ-011 o_int_id  output  3  index of the source being requested.
REQ-012 o_pending  output  N_INPUTS  registered pending-latch vector, unmasked view.

Function
REQ-013 Each i_interrupt bit SHALL pass through SYNC_STAGES flops, then a one-flop edge detector; a 0->1 transition of the synchronized value is an edge event.
REQ-014 Latency: the edge on i_interrupt sampled at clock k SHALL set o_pending at clock k+SYNC_STAGES+1; o_int_req SHALL rise no earlier than clock k+SYNC_STAGES+2.
REQ-015 A pending bit SHALL set on its edge event regardless of mask and SHALL remain set until cleared by an ack.
REQ-016 FSM states: IDLE, REQ, HOLDOFF.
REQ-017 IDLE -> REQ when (o_pending & ~mask) != 0; o_int_id latched to the lowest set unmasked index; o_int_req=1 from the next cycle.
REQ-018 In REQ, o_int_id and o_int_req SHALL stay stable until i_int_ack, even if the mask changes or new edges arrive.
REQ-019 REQ + i_int_ack: clear pending[o_int_id], deassert o_int_req next cycle, go to HOLDOFF, load the counter with HOLDOFF_CYCLES.
REQ-020 HOLDOFF: decrement each cycle; at 0 go to IDLE; with HOLDOFF_CYCLES=0 the FSM SHALL transition REQ->IDLE directly.
REQ-021 i_int_ack in IDLE or HOLDOFF SHALL be ignored.
REQ-022 Same-cycle edge event and ack clear on the same bit: set wins; the bit stays pending.
REQ-023 i_mask_wr takes effect the following cycle; masking a pending bit hides it from arbitration but does not clear it.
REQ-024 Simultaneous unmasked pending bits SHALL be serviced in ascending index order, one request per ack.

Reset
REQ-025 On i_rst: synchronizer/edge flops 0, o_pending 0, mask all ones, FSM IDLE, counter 0, o_int_req 0, o_int_id 0.
REQ-026 Reset asserted mid-request SHALL drop o_int_req asynchronously and discard all pending events.
REQ-027 A line held high through reset release SHALL NOT generate an edge.

Configuration
REQ-028 Macro INTERRUPT_CONDITIONER_GLITCH_FILTER_EN defined: the synchronized value must be high for 2 consecutive cycles before the edge is recognized (latency +1, 1-cycle pulses rejected).
REQ-029 Macro absent: no filter; a single-cycle high synchronized sample SHALL produce an edge event.

Structure
REQ-030 Package interrupt_conditioner_pkg SHALL hold the FSM state enum, the holdoff counter width (4), and the id width (3).
REQ-031 Sub-module interrupt_conditioner_sync SHALL implement one input's synchronizer, optional filter, and edge detect, instantiated N_INPUTS times.

Verification
REQ-032 Mask 0, one-cycle pulse on bit 2 -> o_pending=0100 at k+3, o_int_req=1 with id=2 at k+4, ack -> req low, pending=0 next cycle.
REQ-033 Bits 1 and 3 pulsed in the same cycle -> id=1 first, then id=3 exactly HOLDOFF_CYCLES+1 cycles after the first ack.
REQ-034 Mask all ones, pulse bit 0 -> pending=0001, no request; write mask 0 -> request with id=0 one cycle later.
REQ-035 New edge on bit 0 coinciding with the ack of id=0 -> pending[0] stays 1, second request after holdoff.
REQ-036 i_rst asserted while o_int_req=1 -> req and pending 0 immediately; line held high through release -> no request.
REQ-037 With the filter macro defined, a 1-cycle pulse -> no pending set; a 3-cycle pulse -> pending set at k+4.
